// File: rtl/alu_issue_stage.sv
// Two-slot execute-front stage: decodes RV32I into ALU operands (S1) and captures ALU result/branch outcome (S2).
// Optional operand bypass into S1 is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic            res_we,
    output logic            res_load,
    output logic            res_store,
    output logic [XLEN-1:0] res_store_data,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            illegal
);
    localparam int unsigned OPW = 4;
    localparam int unsigned RW  = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // S1 state
    logic            s1_v_q, s1_v_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [RW-1:0]   s1_rd_q, s1_rd_d;
    logic            s1_we_q, s1_we_d, s1_load_q, s1_load_d, s1_store_q, s1_store_d;
    logic [XLEN-1:0] s1_sdata_q, s1_sdata_d, s1_target_q, s1_target_d;
    logic            s1_jump_q, s1_jump_d, s1_branch_q, s1_branch_d;
    logic            s1_brlt_q, s1_brlt_d, s1_brinv_q, s1_brinv_d, s1_illegal_q, s1_illegal_d;

    // S2 state
    logic            s2_v_q, s2_v_d;
    logic [XLEN-1:0] res_data_q, res_data_d, res_sdata_q, res_sdata_d, br_target_q, br_target_d;
    logic [RW-1:0]   res_rd_q, res_rd_d;
    logic            res_we_q, res_we_d, res_load_q, res_load_d, res_store_q, res_store_d;
    logic            br_taken_q, br_taken_d, illegal_q, illegal_d;

    logic            s1_adv, accept, xfer, br_cond;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            i30;

    assign s1_adv   = !s2_v_q || res_ready;
    assign in_ready = !s1_v_q || s1_adv;
    assign accept   = in_valid && in_ready && !flush;
    // A flushed S1 entry is squashed rather than promoted.
    assign xfer     = s1_v_q && s1_adv && !flush;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign i30    = instr[30];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

`ifdef ALU_ISSUE_FWD_EN
    logic [RW-1:0] rs1_idx, rs2_idx;
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];

    // Younger producer in S1 wins over S2; x0 and load addresses are never bypassed.
    always_comb begin
        rs1_fwd = rs1_val;
        rs2_fwd = rs2_val;
        if (rs1_idx != '0) begin
            if (s1_v_q && s1_we_q && !s1_load_q && s1_rd_q == rs1_idx)
                rs1_fwd = alu_out;
            else if (s2_v_q && res_we_q && !res_load_q && res_rd_q == rs1_idx)
                rs1_fwd = res_data_q;
        end
        if (rs2_idx != '0) begin
            if (s1_v_q && s1_we_q && !s1_load_q && s1_rd_q == rs2_idx)
                rs2_fwd = alu_out;
            else if (s2_v_q && res_we_q && !res_load_q && res_rd_q == rs2_idx)
                rs2_fwd = res_data_q;
        end
    end
`else
    assign rs1_fwd = rs1_val;
    assign rs2_fwd = rs2_val;
`endif

    // Decode and S1 next state
    always_comb begin
        s1_v_d       = s1_v_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        s1_rd_d      = s1_rd_q;
        s1_we_d      = s1_we_q;
        s1_load_d    = s1_load_q;
        s1_store_d   = s1_store_q;
        s1_sdata_d   = s1_sdata_q;
        s1_target_d  = s1_target_q;
        s1_jump_d    = s1_jump_q;
        s1_branch_d  = s1_branch_q;
        s1_brlt_d    = s1_brlt_q;
        s1_brinv_d   = s1_brinv_q;
        s1_illegal_d = s1_illegal_q;
        if (flush) begin
            s1_v_d = 1'b0;
        end else if (accept) begin
            s1_v_d       = 1'b1;
            alu_a_d      = '0;
            alu_b_d      = '0;
            alu_op_d     = '0;
            s1_rd_d      = instr[11:7];
            s1_we_d      = 1'b0;
            s1_load_d    = 1'b0;
            s1_store_d   = 1'b0;
            s1_sdata_d   = rs2_fwd;
            s1_target_d  = '0;
            s1_jump_d    = 1'b0;
            s1_branch_d  = 1'b0;
            s1_brlt_d    = 1'b0;
            s1_brinv_d   = f3[0];
            s1_illegal_d = 1'b0;
            case (opcode)
                OPC_OP: begin
                    alu_a_d = rs1_fwd; alu_b_d = rs2_fwd; alu_op_d = {i30, f3}; s1_we_d = 1'b1;
                end
                OPC_OP_IMM: begin
                    alu_a_d = rs1_fwd; alu_b_d = imm_i; alu_op_d = {(f3 == 3'b101) && i30, f3};
                    s1_we_d = 1'b1;
                end
                OPC_LUI: begin
                    alu_b_d = imm_u; s1_we_d = 1'b1;
                end
                OPC_AUIPC: begin
                    alu_a_d = pc; alu_b_d = imm_u; s1_we_d = 1'b1;
                end
                OPC_JAL: begin
                    alu_a_d = pc; alu_b_d = XLEN'(4); s1_we_d = 1'b1; s1_jump_d = 1'b1;
                    s1_target_d = pc + imm_j;
                end
                OPC_JALR: begin
                    alu_a_d = pc; alu_b_d = XLEN'(4); s1_we_d = 1'b1; s1_jump_d = 1'b1;
                    s1_target_d = (rs1_fwd + imm_i) & ~XLEN'(1);
                end
                OPC_LOAD: begin
                    alu_a_d = rs1_fwd; alu_b_d = imm_i; s1_load_d = 1'b1;
                end
                OPC_STORE: begin
                    alu_a_d = rs1_fwd; alu_b_d = imm_s; s1_store_d = 1'b1;
                end
                OPC_BRANCH: begin
                    if (f3[2:1] == 2'b01) begin
                        s1_illegal_d = 1'b1;
                    end else begin
                        alu_a_d     = rs1_fwd;
                        alu_b_d     = rs2_fwd;
                        alu_op_d    = (f3[2:1] == 2'b00) ? 4'b1000 : {2'b00, 1'b1, f3[1]};
                        s1_brlt_d   = f3[2];
                        s1_branch_d = 1'b1;
                        s1_target_d = pc + imm_b;
                    end
                end
                default: s1_illegal_d = 1'b1;
            endcase
            if (instr[11:7] == '0) s1_we_d = 1'b0;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
    end

    // Branch outcome comes from the ALU: SUB for equality, SLT/SLTU for ordering.
    assign br_cond = s1_brlt_q ? alu_out[0] : (alu_out == '0);

    // S2 next state
    always_comb begin
        s2_v_d      = s2_v_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_we_d    = res_we_q;
        res_load_d  = res_load_q;
        res_store_d = res_store_q;
        res_sdata_d = res_sdata_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        illegal_d   = illegal_q;
        if (xfer) begin
            s2_v_d      = 1'b1;
            res_data_d  = alu_out;
            res_rd_d    = s1_rd_q;
            res_we_d    = s1_we_q;
            res_load_d  = s1_load_q;
            res_store_d = s1_store_q;
            res_sdata_d = s1_sdata_q;
            br_taken_d  = s1_jump_q || (s1_branch_q && (br_cond ^ s1_brinv_q));
            br_target_d = s1_target_q;
            illegal_d   = s1_illegal_q;
        end else if (res_ready) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0; alu_a_q <= '0; alu_b_q <= '0; alu_op_q <= '0;
            s1_rd_q <= '0; s1_we_q <= 1'b0; s1_load_q <= 1'b0; s1_store_q <= 1'b0;
            s1_sdata_q <= '0; s1_target_q <= '0; s1_jump_q <= 1'b0; s1_branch_q <= 1'b0;
            s1_brlt_q <= 1'b0; s1_brinv_q <= 1'b0; s1_illegal_q <= 1'b0;
            s2_v_q <= 1'b0; res_data_q <= '0; res_rd_q <= '0; res_we_q <= 1'b0;
            res_load_q <= 1'b0; res_store_q <= 1'b0; res_sdata_q <= '0;
            br_taken_q <= 1'b0; br_target_q <= '0; illegal_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d; alu_a_q <= alu_a_d; alu_b_q <= alu_b_d; alu_op_q <= alu_op_d;
            s1_rd_q <= s1_rd_d; s1_we_q <= s1_we_d; s1_load_q <= s1_load_d; s1_store_q <= s1_store_d;
            s1_sdata_q <= s1_sdata_d; s1_target_q <= s1_target_d; s1_jump_q <= s1_jump_d;
            s1_branch_q <= s1_branch_d; s1_brlt_q <= s1_brlt_d; s1_brinv_q <= s1_brinv_d;
            s1_illegal_q <= s1_illegal_d;
            s2_v_q <= s2_v_d; res_data_q <= res_data_d; res_rd_q <= res_rd_d; res_we_q <= res_we_d;
            res_load_q <= res_load_d; res_store_q <= res_store_d; res_sdata_q <= res_sdata_d;
            br_taken_q <= br_taken_d; br_target_q <= br_target_d; illegal_q <= illegal_d;
        end
    end

    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;
    assign res_valid      = s2_v_q;
    assign res_data       = res_data_q;
    assign res_rd         = res_rd_q;
    assign res_we         = res_we_q;
    assign res_load       = res_load_q;
    assign res_store      = res_store_q;
    assign res_store_data = res_sdata_q;
    assign br_taken       = br_taken_q;
    assign br_target      = br_target_q;
    assign illegal        = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; a small behavioural ALU closes the alu_op/alu_out loop.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, res_valid, res_ready;
    logic [31:0] instr, pc, rs1_val, rs2_val, alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic [31:0] res_data, res_store_data, br_target;
    logic [4:0]  res_rd;
    logic        res_we, res_load, res_store, br_taken, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_rd(res_rd), .res_we(res_we), .res_load(res_load),
        .res_store(res_store), .res_store_data(res_store_data), .br_taken(br_taken),
        .br_target(br_target), .illegal(illegal)
    );

    always_comb begin
        case (alu_op)
            4'b0000: alu_out = alu_a + alu_b;
            4'b1000: alu_out = alu_a - alu_b;
            4'b0001: alu_out = alu_a << alu_b[4:0];
            4'b0010: alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'b0011: alu_out = {31'b0, alu_a < alu_b};
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = alu_a >> alu_b[4:0];
            4'b1101: alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
            4'b0110: alu_out = alu_a | alu_b;
            4'b0111: alu_out = alu_a & alu_b;
            default: alu_out = 32'b0;
        endcase
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drain S2, present one instruction for a single cycle; it sits in S1 on return.
    task automatic issue(input logic [31:0] iw, input logic [31:0] p, a, b);
        tick();
        instr = iw; pc = p; rs1_val = a; rs2_val = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
        instr = '0; pc = '0; rs1_val = '0; rs2_val = '0;
        tick(); tick();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // ADD x3,x1,x2
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7);
        chk("add_s1_a", alu_a, 32'd5);
        chk("add_s1_b", alu_b, 32'd7);
        chk("add_s1_res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("add_res_valid", 32'(res_valid), 32'd1);
        chk("add_res_data", res_data, 32'd12);
        chk("add_res_rd", 32'(res_rd), 32'd3);
        chk("add_res_we", 32'(res_we), 32'd1);

        // SRAI / SRLI x4,x1,4
        issue(enc_i(12'h404, 5'd1, 3'b101, 5'd4, 7'b0010011), 32'h0, 32'h8000_0000, 32'h0);
        chk("srai_op", 32'(alu_op), 32'hD);
        tick();
        chk("srai_data", res_data, 32'hF800_0000);
        issue(enc_i(12'h004, 5'd1, 3'b101, 5'd4, 7'b0010011), 32'h0, 32'h8000_0000, 32'h0);
        chk("srli_op", 32'(alu_op), 32'h5);
        tick();
        chk("srli_data", res_data, 32'h0800_0000);

        // BLT / BGEU / BNE at pc 0x100, offset -8
        issue(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b100), 32'h100, 32'hFFFF_FFFF, 32'd1);
        chk("blt_op", 32'(alu_op), 32'h2);
        tick();
        chk("blt_taken", 32'(br_taken), 32'd1);
        chk("blt_target", br_target, 32'hF8);
        chk("blt_we", 32'(res_we), 32'd0);
        issue(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b111), 32'h100, 32'hFFFF_FFFF, 32'd1);
        chk("bgeu_op", 32'(alu_op), 32'h3);
        tick();
        chk("bgeu_taken", 32'(br_taken), 32'd1);
        issue(enc_b(13'h0010, 5'd2, 5'd1, 3'b001), 32'h100, 32'd3, 32'd3);
        tick();
        chk("bne_taken", 32'(br_taken), 32'd0);
        chk("bne_target", br_target, 32'h110);

        // JAL x1,+16 at 0x200
        issue(enc_j(21'h10, 5'd1), 32'h200, 32'h0, 32'h0);
        tick();
        chk("jal_link", res_data, 32'h204);
        chk("jal_taken", 32'(br_taken), 32'd1);
        chk("jal_target", br_target, 32'h210);
        chk("jal_we", 32'(res_we), 32'd1);

        // JALR x5, 6(x1) clears bit 0 of the target
        issue(enc_i(12'h006, 5'd1, 3'b000, 5'd5, 7'b1100111), 32'h300, 32'h1001, 32'h0);
        tick();
        chk("jalr_target", br_target, 32'h1006);
        chk("jalr_link", res_data, 32'h304);

        // LUI x5 and SW x2,8(x1)
        issue({20'h12345, 5'd5, 7'b0110111}, 32'h0, 32'h0, 32'h0);
        tick();
        chk("lui_data", res_data, 32'h1234_5000);
        issue(enc_s(12'd8, 5'd2, 5'd1), 32'h0, 32'h1000, 32'hDEAD_BEEF);
        tick();
        chk("sw_addr", res_data, 32'h1008);
        chk("sw_store", 32'(res_store), 32'd1);
        chk("sw_sdata", res_store_data, 32'hDEAD_BEEF);
        chk("sw_we", 32'(res_we), 32'd0);

        // Illegal opcode and reserved branch funct3
        issue(32'h0000_00FF, 32'h0, 32'h0, 32'h0);
        tick();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_we", 32'(res_we), 32'd0);
        issue(enc_b(13'h0010, 5'd2, 5'd1, 3'b010), 32'h100, 32'd3, 32'd3);
        tick();
        chk("ill_br_flag", 32'(illegal), 32'd1);
        chk("ill_br_taken", 32'(br_taken), 32'd0);

        // Backpressure: three ADDI x6/x7/x8 while res_ready=0 for three cycles
        tick(); tick();
        res_ready = 1'b0;
        instr = enc_i(12'd1, 5'd0, 3'b000, 5'd6, 7'b0010011); rs1_val = 32'd100; in_valid = 1'b1;
        tick();
        instr = enc_i(12'd2, 5'd0, 3'b000, 5'd7, 7'b0010011);
        tick();
        instr = enc_i(12'd3, 5'd0, 3'b000, 5'd8, 7'b0010011);
        chk("bp_in_ready0", 32'(in_ready), 32'd0);
        chk("bp_first", res_data, 32'd101);
        tick();
        chk("bp_hold_valid", 32'(res_valid), 32'd1);
        chk("bp_hold_data", res_data, 32'd101);
        chk("bp_hold_rd", 32'(res_rd), 32'd6);
        tick();
        chk("bp_in_ready1", 32'(in_ready), 32'd0);
        res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_second", res_data, 32'd102);
        chk("bp_second_rd", 32'(res_rd), 32'd7);
        tick();
        chk("bp_third", res_data, 32'd103);
        chk("bp_third_rd", 32'(res_rd), 32'd8);
        tick();
        chk("bp_drained", 32'(res_valid), 32'd0);

        // Flush with S1 and S2 occupied and a new instruction offered
        res_ready = 1'b0; rs1_val = 32'd0; in_valid = 1'b1;
        instr = enc_i(12'd50, 5'd0, 3'b000, 5'd9, 7'b0010011);
        tick();
        instr = enc_i(12'd60, 5'd0, 3'b000, 5'd10, 7'b0010011);
        tick();
        instr = enc_i(12'd70, 5'd0, 3'b000, 5'd11, 7'b0010011);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_s2_data", res_data, 32'd50);
        res_ready = 1'b1;
        tick();
        chk("fl_s2_gone", 32'(res_valid), 32'd0);
        tick();
        chk("fl_no_ghost", 32'(res_valid), 32'd0);
        // Flush while S1 is empty drops the offered instruction
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tick();
        chk("fl_in_dropped", 32'(res_valid), 32'd0);

        // Reset mid-stream
        res_ready = 1'b0;
        issue(enc_i(12'd5, 5'd0, 3'b000, 5'd12, 7'b0010011), 32'h0, 32'h0, 32'h0);
        tick();
        chk("mrst_pre", 32'(res_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; res_ready = 1'b1;
        chk("mrst_valid", 32'(res_valid), 32'd0);
        chk("mrst_data", res_data, 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);

        // Bypass: ADDI x1,x0,9 then ADD x2,x1,x1 (from S1), then again with one gap (from S2)
        tick();
        rs1_val = 32'd0; rs2_val = 32'd0; in_valid = 1'b1;
        instr = enc_i(12'd9, 5'd0, 3'b000, 5'd1, 7'b0010011);
        tick();
        instr = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);
        tick();
        in_valid = 1'b0;
        tick();
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_s1", res_data, 32'd18);
`else
        chk("fwd_s1", res_data, 32'd0);
`endif
        tick(); tick();
        in_valid = 1'b1;
        instr = enc_i(12'd9, 5'd0, 3'b000, 5'd1, 7'b0010011);
        tick();
        instr = enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011);
        tick();
        instr = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);
        tick();
        in_valid = 1'b0;
        tick();
        chk("fwd_s2_rd", 32'(res_rd), 32'd2);
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_s2", res_data, 32'd18);
`else
        chk("fwd_s2", res_data, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
